// File: rtl/toggle_cover_pkg.sv
// Shared constants and helpers for the toggle coverage collector.
package toggle_cover_pkg;

  // Width of the global cover-index bus.
  localparam int COVER_IDX_W = 64;

  // Default global cover-point count for the design being instrumented.
  localparam int COVER_TOTAL_DEFAULT = 8940;

  // Output stage occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/toggle_cover_prio_enc.sv
// Lowest-set-bit priority encoder: index of the least significant set bit of
// vec, plus a flag telling whether any bit was set at all.
module toggle_cover_prio_enc
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = 42,
  parameter int IW    = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             found
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: sticky per-point hit bitmap, one report per
// newly covered point per epoch, drained lowest index first through a
// single-entry output register with valid/ready handshake.
module toggle_cover_collector
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH       = 42,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = COVER_TOTAL_DEFAULT,
  localparam int CW         = clog2(WIDTH + 1),
  localparam int IW         = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       valid,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COVER_IDX_W-1:0] out_index,
  output logic [CW-1:0]          hit_count,
  output logic                   all_covered,
  output logic                   busy
);

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("toggle_cover_collector: WIDTH %0d outside 1..1024", WIDTH);
  end
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("toggle_cover_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] hit, pending, new_hits, lowest, take_mask;
  logic [CW-1:0]    cnt_new;
  logic [IW-1:0]    enc_idx;
  logic             enc_found;
  logic             load;
  ostate_t          state, state_next;

  toggle_cover_prio_enc #(.WIDTH(WIDTH), .IW(IW)) u_enc (
    .vec   (pending),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Points hit for the first time this epoch, and how many of them.
  always_comb begin
    new_hits = enable ? (valid & ~hit) : '0;
    cnt_new  = '0;
    for (int i = 0; i < WIDTH; i++) cnt_new = cnt_new + CW'(new_hits[i]);
  end

  // Output stage next state; a load always uses the pre-edge pending map.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_EMPTY: if (enc_found) begin
        load       = 1'b1;
        state_next = ST_FULL;
      end
      ST_FULL: if (out_ready) begin
        load       = enc_found;
        state_next = enc_found ? ST_FULL : ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // One-hot of the pending bit being moved into the output register.
  always_comb begin
    lowest    = pending & (~pending + WIDTH'(1));
    take_mask = load ? lowest : '0;
  end

  // Output stage state register; reset and clear both drop any report.
  always_ff @(posedge clock) begin
    if (!reset || clear) state <= ST_EMPTY;
    else                 state <= state_next;
  end

  // Coverage bitmaps, counter and report index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit       <= '0;
      pending   <= '0;
      hit_count <= '0;
      out_index <= '0;
    end else if (clear) begin
      hit       <= '0;
      pending   <= '0;
      hit_count <= '0;
    end else begin
      hit       <= hit | new_hits;
      pending   <= (pending & ~take_mask) | new_hits;
      hit_count <= hit_count + cnt_new;
      if (load) out_index <= COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(enc_idx);
    end
  end

  assign out_valid   = (state == ST_FULL);
  assign all_covered = (hit_count == CW'(WIDTH));
  assign busy        = out_valid | (|pending);

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed self-checking bench for toggle_cover_collector (WIDTH=42, base 100).
module tb_toggle_cover_collector;

  localparam int W = 42;

  logic          clock = 1'b0;
  logic          reset, enable, clear, out_ready;
  logic [W-1:0]  valid;
  logic          out_valid, all_covered, busy;
  logic [63:0]   out_index;
  logic [5:0]    hit_count;

  int vectors = 0;
  int miscompares = 0;

  toggle_cover_collector #(.WIDTH(W), .COVER_INDEX(100), .COVER_TOTAL(8940)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .valid       (valid),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .hit_count   (hit_count),
    .all_covered (all_covered),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    valid = '0; clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1; valid = '1;
    step(); step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++; if (out_index !== 64'd0) begin miscompares++; $display("FAIL reset_out_index got %0d want 0", out_index); end
    vectors++; if (hit_count !== 6'd0) begin miscompares++; $display("FAIL reset_hit_count got %0d want 0", hit_count); end
    vectors++; if (all_covered !== 1'b0) begin miscompares++; $display("FAIL reset_all_covered got %0b want 0", all_covered); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    valid = '0; reset = 1'b1; step();
  endtask

  task automatic test_single();
    do_clear(); out_ready = 1'b1;
    valid = '0; valid[5] = 1'b1; step(); valid = '0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_latency out_valid got %0b want 0", out_valid); end
    vectors++; if (hit_count !== 6'd1) begin miscompares++; $display("FAIL single_hit_count got %0d want 1", hit_count); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_index !== 64'd105) begin miscompares++; $display("FAIL single_report got v=%0b idx=%0d want v=1 idx=105", out_valid, out_index); end
    step();
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_idle got v=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_simultaneous();
    logic [63:0] exp [3];
    exp[0] = 64'd100; exp[1] = 64'd103; exp[2] = 64'd141;
    do_clear(); out_ready = 1'b1;
    valid = '0; valid[0] = 1'b1; valid[3] = 1'b1; valid[41] = 1'b1; step(); valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (out_valid !== 1'b1 || out_index !== exp[k]) begin miscompares++; $display("FAIL simul_report%0d got v=%0b idx=%0d want v=1 idx=%0d", k, out_valid, out_index, exp[k]); end
    end
    step();
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || hit_count !== 6'd3) begin miscompares++; $display("FAIL simul_end got v=%0b busy=%0b cnt=%0d want 0 0 3", out_valid, busy, hit_count); end
  endtask

  task automatic test_repeat_hit();
    int reports = 0;
    do_clear(); out_ready = 1'b1;
    valid = '0; valid[7] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 10) valid = '0;
      step();
      if (out_valid) begin
        reports++;
        vectors++; if (out_index !== 64'd107) begin miscompares++; $display("FAIL repeat_index got %0d want 107", out_index); end
      end
    end
    vectors++; if (reports !== 1) begin miscompares++; $display("FAIL repeat_reports got %0d want 1", reports); end
    vectors++; if (hit_count !== 6'd1) begin miscompares++; $display("FAIL repeat_hit_count got %0d want 1", hit_count); end
  endtask

  task automatic test_backpressure();
    do_clear(); out_ready = 1'b0;
    valid = '0; valid[7] = 1'b1; step(); valid = '0; step();
    vectors++; if (out_valid !== 1'b1 || out_index !== 64'd107) begin miscompares++; $display("FAIL bp_first got v=%0b idx=%0d want 1 107", out_valid, out_index); end
    valid[2] = 1'b1; step(); valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++; if (out_valid !== 1'b1 || out_index !== 64'd107) begin miscompares++; $display("FAIL bp_hold%0d got v=%0b idx=%0d want 1 107", c, out_valid, out_index); end
    end
    out_ready = 1'b1; step();
    vectors++; if (out_valid !== 1'b1 || out_index !== 64'd102) begin miscompares++; $display("FAIL bp_next got v=%0b idx=%0d want 1 102", out_valid, out_index); end
    step();
    vectors++; if (out_valid !== 1'b0 || hit_count !== 6'd2) begin miscompares++; $display("FAIL bp_end got v=%0b cnt=%0d want 0 2", out_valid, hit_count); end
  endtask

  task automatic test_enable_low();
    do_clear(); out_ready = 1'b1; enable = 1'b0;
    valid = '0; valid[9] = 1'b1; step(); step(); valid = '0; step();
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || hit_count !== 6'd0) begin miscompares++; $display("FAIL enable_low got v=%0b busy=%0b cnt=%0d want 0 0 0", out_valid, busy, hit_count); end
    enable = 1'b1;
  endtask

  task automatic test_all_covered();
    int reports = 0;
    do_clear(); out_ready = 1'b1;
    valid = '1; step(); valid = '0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (out_valid) begin
        vectors++; if (out_index !== 64'(100 + reports)) begin miscompares++; $display("FAIL all_order got %0d want %0d", out_index, 100 + reports); end
        reports++;
      end
    end
    vectors++; if (reports !== 42) begin miscompares++; $display("FAIL all_reports got %0d want 42", reports); end
    vectors++; if (hit_count !== 6'd42 || all_covered !== 1'b1) begin miscompares++; $display("FAIL all_cov got cnt=%0d ac=%0b want 42 1", hit_count, all_covered); end
    // Hits presented in the clear cycle are ignored.
    valid = '1; clear = 1'b1; step(); clear = 1'b0; valid = '0;
    vectors++; if (hit_count !== 6'd0 || all_covered !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL all_clear got cnt=%0d ac=%0b busy=%0b want 0 0 0", hit_count, all_covered, busy); end
    valid[5] = 1'b1; step(); valid = '0; step();
    vectors++; if (out_valid !== 1'b1 || out_index !== 64'd105) begin miscompares++; $display("FAIL all_rehit got v=%0b idx=%0d want 1 105", out_valid, out_index); end
    step();
  endtask

  task automatic test_reset_mid_drain();
    int reports = 0;
    do_clear(); out_ready = 1'b1;
    valid = '0; valid[5:1] = 5'b11111; step(); valid = '0;
    step();
    vectors++; if (out_valid !== 1'b1 || out_index !== 64'd101) begin miscompares++; $display("FAIL drain_first got v=%0b idx=%0d want 1 101", out_valid, out_index); end
    reset = 1'b0; step(); reset = 1'b1;
    vectors++; if (out_valid !== 1'b0 || hit_count !== 6'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL drain_reset got v=%0b cnt=%0d busy=%0b want 0 0 0", out_valid, hit_count, busy); end
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) reports++;
    end
    vectors++; if (reports !== 0) begin miscompares++; $display("FAIL drain_after got %0d reports want 0", reports); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_repeat_hit();
    test_backpressure();
    test_enable_low();
    test_all_covered();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
